// File: rtl/dram_requester.sv
// Single-word read/write requester driving DRAM strobes with fixed read latency
// and write pulse width; read data is returned over a valid/ready channel.
module dram_requester #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_CYC = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              wr_done,
  output logic              busy,
  output logic              RD,
  output logic              WR,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut
);

  localparam int unsigned CntMax = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [CntW-1:0] RdLoad = CntW'(RD_LAT);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_CYC);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntTwo = CntW'(2);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;

  assign req_ready = (state == StIdle);
  assign busy      = (state != StIdle);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= StIdle;
      cnt       <= '0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      wr_done   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      Addr      <= '0;
      DataIn    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            Addr <= req_addr;
            if (req_wr) begin
              DataIn  <= req_wdata;
              WR      <= 1'b1;
              wr_done <= (WR_CYC == 1);
              cnt     <= WrLoad;
              state   <= StWrite;
            end else begin
              RD    <= 1'b1;
              cnt   <= RdLoad;
              state <= StRead;
            end
          end
        end
        StWrite: begin
          if (cnt == CntOne) begin
            WR      <= 1'b0;
            wr_done <= 1'b0;
            state   <= StIdle;
          end else begin
            // wr_done must coincide with the final WR cycle
            wr_done <= (cnt == CntTwo);
            cnt     <= cnt - CntOne;
          end
        end
        StRead: begin
          if (cnt == CntOne) begin
            RD        <= 1'b0;
            rsp_data  <= DataOut;
            rsp_valid <= 1'b1;
            state     <= StResp;
          end else begin
            cnt <= cnt - CntOne;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_requester.sv
// Scoreboard bench: directed requests push expected completions, a monitor pops
// them on wr_done / response handshakes. A second instance covers longer timings.
module tb_dram_requester;

  logic        Clk = 1'b0;
  logic        Rst;
  always #5 Clk = ~Clk;

  // Instance 1: default timing
  logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, wr_done, busy, RD, WR;
  logic [15:0] req_addr, req_wdata, rsp_data, Addr, DataIn, DataOut;
  logic [15:0] mem [256];

  dram_requester u_dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .wr_done(wr_done), .busy(busy), .RD(RD), .WR(WR), .Addr(Addr),
    .DataIn(DataIn), .DataOut(DataOut)
  );

  assign DataOut = mem[Addr[7:0]];
  always @(posedge Clk) if (WR) mem[Addr[7:0]] <= DataIn;

  // Instance 2: RD_LAT=3, WR_CYC=2
  logic        req_valid2, req_ready2, req_wr2, rsp_valid2, rsp_ready2, wr_done2, busy2;
  logic        RD2, WR2;
  logic [15:0] req_addr2, req_wdata2, rsp_data2, Addr2, DataIn2, DataOut2;
  logic [15:0] mem2 [256];

  dram_requester #(.RD_LAT(3), .WR_CYC(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_wr(req_wr2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .wr_done(wr_done2), .busy(busy2),
    .RD(RD2), .WR(WR2), .Addr(Addr2), .DataIn(DataIn2), .DataOut(DataOut2)
  );

  assign DataOut2 = mem2[Addr2[7:0]];
  always @(posedge Clk) if (WR2) mem2[Addr2[7:0]] <= DataIn2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_wr;
    logic [15:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic is_wr, input logic [15:0] data);
    exp_t e;
    e.is_wr = is_wr;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor for instance 1
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst && (wr_done || (rsp_valid && rsp_ready))) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_completion", {30'd0, wr_done, rsp_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_kind_is_wr", {31'd0, wr_done}, {31'd0, e.is_wr});
        if (!e.is_wr) check("sb_rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
      end
    end
  end

  // Activity monitor for instance 2
  int          cyc = 0, wr_cyc2 = 0, rd_cyc2 = 0, both2 = 0, done2 = 0, rsp2 = 0;
  int          acc_n = 0;
  int          acc_t[$];
  logic [15:0] rsp_seen2 = '0;
  always @(negedge Clk) begin
    cyc++;
    if (!Rst) begin
      if (WR2) wr_cyc2++;
      if (RD2) rd_cyc2++;
      if (RD2 && WR2) both2++;
      if (wr_done2) done2++;
      if (req_valid2 && req_ready2) begin
        acc_n++;
        acc_t.push_back(cyc);
      end
      if (rsp_valid2 && rsp_ready2) begin
        rsp2++;
        rsp_seen2 = rsp_data2;
      end
    end
  end

  initial begin
    Rst = 1'b1;
    req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    req_valid2 = 0; req_wr2 = 0; req_addr2 = '0; req_wdata2 = '0; rsp_ready2 = 1;
    step(); step();
    Rst = 1'b0;
    step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_strobes", {28'd0, RD, WR, rsp_valid, wr_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {16'd0, Addr}, 32'h0);

    // Write 0xF00D to 0x5555
    req_valid = 1; req_wr = 1; req_addr = 16'h5555; req_wdata = 16'hF00D;
    push(1'b1, 16'h0);
    step();
    req_valid = 0;
    check("wr_we", {30'd0, WR, RD}, 32'b10);
    check("wr_addr", {16'd0, Addr}, 32'h5555);
    check("wr_data", {16'd0, DataIn}, 32'hF00D);
    check("wr_done", {31'd0, wr_done}, 32'd1);
    check("wr_busy_ready", {30'd0, busy, req_ready}, 32'b10);
    step();
    check("wr_end_we", {31'd0, WR}, 32'd0);
    check("wr_end_ready", {31'd0, req_ready}, 32'd1);

    // Read back with rsp_ready high
    rsp_ready = 1;
    req_valid = 1; req_wr = 0; req_addr = 16'h5555; req_wdata = 16'h0;
    push(1'b0, 16'hF00D);
    step();
    req_valid = 0;
    check("rd_c1_rd", {30'd0, RD, WR}, 32'b10);
    check("rd_c1_addr", {16'd0, Addr}, 32'h5555);
    step();
    check("rd_c2_rd", {30'd0, RD, WR}, 32'b10);
    step();
    check("rd_rsp_valid", {30'd0, rsp_valid, RD}, 32'b10);
    check("rd_rsp_data", {16'd0, rsp_data}, 32'hF00D);
    step();
    check("rd_idle", {29'd0, rsp_valid, req_ready, busy}, 32'b010);

    // Read with response backpressure; a concurrent request must be ignored
    rsp_ready = 0;
    req_valid = 1; req_wr = 0; req_addr = 16'h5555;
    push(1'b0, 16'hF00D);
    step();
    req_valid = 0;
    step(); step();
    req_valid = 1; req_wr = 1; req_addr = 16'h0BAD; req_wdata = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", {16'd0, rsp_data}, 32'hF00D);
      check("bp_req_ready", {29'd0, req_ready, RD, WR}, 32'b000);
      step();
    end
    req_valid = 0;
    rsp_ready = 1;
    step();
    check("bp_release", {30'd0, rsp_valid, req_ready}, 32'b01);
    check("bp_addr_kept", {16'd0, Addr}, 32'h5555);
    check("bp_no_write", {16'd0, mem[8'hAD]} == 32'hDEAD ? 32'd1 : 32'd0, 32'd0);

    // Reset during the 2nd RD cycle
    req_valid = 1; req_wr = 0; req_addr = 16'h5555;
    step();
    req_valid = 0;
    step();
    check("mid_rd_active", {31'd0, RD}, 32'd1);
    Rst = 1;
    step();
    Rst = 0;
    check("mid_rst_rd", {30'd0, RD, busy}, 32'b00);
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("sb_drained", sb_q.size(), 32'd0);

    // Back-to-back write then read on the RD_LAT=3 / WR_CYC=2 instance
    req_valid2 = 1; req_wr2 = 1; req_addr2 = 16'h0100; req_wdata2 = 16'h1111;
    step();
    req_wr2 = 0; req_wdata2 = 16'h0;
    step(); step(); step();
    req_valid2 = 0;
    for (int i = 0; i < 10; i++) step();
    check("b2b_wr_cycles", wr_cyc2, 32'd2);
    check("b2b_rd_cycles", rd_cyc2, 32'd3);
    check("b2b_overlap", both2, 32'd0);
    check("b2b_wr_done", done2, 32'd1);
    check("b2b_accepts", acc_n, 32'd2);
    if (acc_t.size() == 2) check("b2b_accept_gap", acc_t[1] - acc_t[0], 32'd3);
    else check("b2b_accept_list", acc_t.size(), 32'd2);
    check("b2b_rsp_count", rsp2, 32'd1);
    check("b2b_rsp_data", {16'd0, rsp_seen2}, 32'h1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
